// File: rtl/instruction_prefetch_unit_pkg.sv
// Shared constants for the instruction prefetch front end.
package instruction_prefetch_unit_pkg;
  localparam logic [1:0]  AXI_RESP_OKAY      = 2'b00;
  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;
  localparam int unsigned FETCH_STRIDE       = 4;
endpackage

// File: rtl/instruction_prefetch_unit_if.sv
// AXI-Lite read channel (AR + R) between the prefetch master and instruction memory.
interface instruction_prefetch_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic [XLEN-1:0] araddr;
  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] rdata;
  logic [1:0]      rresp;
  logic            rvalid;
  logic            rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/instruction_prefetch_unit_fetch_fifo.sv
// Fetch return FIFO: power-of-two depth, synchronous clear, head read straight from storage registers.
module fetch_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         i_Clock,
  input  logic                         i_Reset,
  input  logic                         i_Clear,
  input  logic                         i_Push,
  input  logic [WIDTH-1:0]             i_Data,
  input  logic                         i_Pop,
  output logic [WIDTH-1:0]             o_Head,
  output logic                         o_Empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_Count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_Mem [DEPTH];
  logic [PTR_W-1:0] r_Rd_Ptr;
  logic [PTR_W-1:0] r_Wr_Ptr;
  logic [CNT_W-1:0] r_Count;
  logic             w_Pop;

  assign w_Pop   = i_Pop && (r_Count != '0);
  assign o_Head  = r_Mem[r_Rd_Ptr];
  assign o_Empty = (r_Count == '0);
  assign o_Count = r_Count;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Rd_Ptr <= '0;
      r_Wr_Ptr <= '0;
      r_Count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_Mem[i] <= '0;
    end else if (i_Clear) begin
      r_Rd_Ptr <= '0;
      r_Wr_Ptr <= '0;
      r_Count  <= '0;
    end else begin
      if (i_Push) begin
        r_Mem[r_Wr_Ptr] <= i_Data;
        r_Wr_Ptr        <= r_Wr_Ptr + 1'b1;
      end
      if (w_Pop) r_Rd_Ptr <= r_Rd_Ptr + 1'b1;
      r_Count <= r_Count + CNT_W'(i_Push) - CNT_W'(w_Pop);
    end
  end

  // Credit accounting upstream must never let a push land on a full FIFO
  always @(posedge i_Clock) begin
    if (!i_Reset && !i_Clear) assert (!(i_Push && (r_Count == CNT_W'(DEPTH))));
  end
endmodule

// File: rtl/instruction_prefetch_unit.sv
// Credit-limited AXI-Lite instruction prefetcher: keeps up to DEPTH reads in flight,
// buffers PC-tagged returns and drops stale beats after a redirect.
module instruction_prefetch_unit
  import instruction_prefetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = XLEN'(DEFAULT_RESET_ADDR)
) (
  input  logic                       i_Clock,
  input  logic                       i_Reset,
  input  logic                       i_Enable,
  input  logic                       i_Redirect,
  input  logic [XLEN-1:0]            i_Redirect_Addr,
  input  logic                       i_Consume,
  output logic [XLEN-1:0]            o_Instruction,
  output logic [XLEN-1:0]            o_PC,
  output logic                       o_Fetch_Error,
  output logic                       o_Instruction_Valid,
  instruction_prefetch_unit_if.master s_axil
);
  localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned USED_W  = CNT_W + 1;
  localparam int unsigned ENTRY_W = 2 * XLEN + 1;

  logic [XLEN-1:0]    r_Fetch_PC;
  logic [XLEN-1:0]    r_Expect_PC;
  logic [XLEN-1:0]    r_Araddr;
  logic               r_Arvalid;
  logic               r_Rready;
  logic [CNT_W-1:0]   r_Inflight;
  logic [CNT_W-1:0]   r_Discard;

  logic [CNT_W-1:0]   w_Fifo_Count;
  logic               w_Fifo_Empty;
  logic [ENTRY_W-1:0] w_Head;
  logic               w_Ar_Fire;
  logic               w_R_Fire;
  logic               w_Push;
  logic               w_Pop;
  logic               w_Issue;
  logic [USED_W-1:0]  w_Used;
  logic [XLEN-1:0]    w_Redirect_PC;
  logic [XLEN-1:0]    w_Issue_PC;

  assign s_axil.araddr  = r_Araddr;
  assign s_axil.arvalid = r_Arvalid;
  assign s_axil.rready  = r_Rready;

  assign w_Ar_Fire     = r_Arvalid && s_axil.arready;
  assign w_R_Fire      = s_axil.rvalid && r_Rready;
  assign w_Redirect_PC = i_Redirect_Addr & ~XLEN'(3);
  assign w_Issue_PC    = i_Redirect ? w_Redirect_PC : r_Fetch_PC;

  // Every slot already buffered, in flight or being requested counts against the credit
  assign w_Used  = USED_W'(w_Fifo_Count) + USED_W'(r_Inflight) + USED_W'(r_Arvalid);
  assign w_Issue = i_Enable && (!r_Arvalid || s_axil.arready) && (w_Used < USED_W'(DEPTH));

  // Any beat seen in a redirect cycle, or while older beats remain to drop, is stale
  assign w_Push = w_R_Fire && !i_Redirect && (r_Discard == '0);
  assign w_Pop  = i_Consume && o_Instruction_Valid;

  assign o_Instruction_Valid = !w_Fifo_Empty && !i_Redirect;
  assign {o_PC, o_Instruction, o_Fetch_Error} = w_Head;

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_Fetch_PC  <= RESET_ADDR;
      r_Expect_PC <= RESET_ADDR;
      r_Araddr    <= '0;
      r_Arvalid   <= 1'b0;
      r_Rready    <= 1'b0;
      r_Inflight  <= '0;
      r_Discard   <= '0;
    end else begin
      r_Rready <= 1'b1;

      // r_Fetch_PC holds the next address not yet placed on the AR channel
      if (w_Issue) begin
        r_Arvalid  <= 1'b1;
        r_Araddr   <= w_Issue_PC;
        r_Fetch_PC <= w_Issue_PC + XLEN'(FETCH_STRIDE);
      end else begin
        if (w_Ar_Fire) r_Arvalid <= 1'b0;
        if (i_Redirect) r_Fetch_PC <= w_Redirect_PC;
      end

      r_Inflight <= r_Inflight + CNT_W'(w_Ar_Fire) - CNT_W'(w_R_Fire);

      if (i_Redirect) begin
        r_Discard   <= r_Inflight + CNT_W'(r_Arvalid) - CNT_W'(w_R_Fire);
        r_Expect_PC <= w_Redirect_PC;
      end else begin
        if (w_R_Fire && (r_Discard != '0)) r_Discard <= r_Discard - 1'b1;
        if (w_Push) r_Expect_PC <= r_Expect_PC + XLEN'(FETCH_STRIDE);
      end
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fetch_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Clear (i_Redirect),
    .i_Push  (w_Push),
    .i_Data  ({r_Expect_PC, s_axil.rdata, (s_axil.rresp != AXI_RESP_OKAY)}),
    .i_Pop   (w_Pop),
    .o_Head  (w_Head),
    .o_Empty (w_Fifo_Empty),
    .o_Count (w_Fifo_Count)
  );
endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed bench for instruction_prefetch_unit against a latency-programmable AXI-Lite slave model.
module tb_instruction_prefetch_unit;
  logic        clk;
  logic        i_Reset;
  logic        i_Enable;
  logic        i_Redirect;
  logic [31:0] i_Redirect_Addr;
  logic        i_Consume;
  logic [31:0] o_Instruction;
  logic [31:0] o_PC;
  logic        o_Fetch_Error;
  logic        o_Instruction_Valid;

  instruction_prefetch_unit_if #(.XLEN(32)) axil ();

  instruction_prefetch_unit #(
    .XLEN       (32),
    .DEPTH      (4),
    .RESET_ADDR (32'h0000_0000)
  ) dut (
    .i_Clock             (clk),
    .i_Reset             (i_Reset),
    .i_Enable            (i_Enable),
    .i_Redirect          (i_Redirect),
    .i_Redirect_Addr     (i_Redirect_Addr),
    .i_Consume           (i_Consume),
    .o_Instruction       (o_Instruction),
    .o_PC                (o_PC),
    .o_Fetch_Error       (o_Fetch_Error),
    .o_Instruction_Valid (o_Instruction_Valid),
    .s_axil              (axil)
  );

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  int          lat          = 0;
  logic        force_ar_low = 1'b0;
  logic        err_en       = 1'b0;
  logic [31:0] err_addr     = 32'h0;
  logic [31:0] q_addr [$];
  int          q_due  [$];
  logic [31:0] ar_log [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model updates on the falling edge; arready is set before the handshake test
  always @(negedge clk) begin
    if (i_Reset) begin
      q_addr.delete();
      q_due.delete();
      axil.rvalid  = 1'b0;
      axil.rdata   = '0;
      axil.rresp   = 2'b00;
      axil.arready = !force_ar_low;
    end else begin
      axil.rvalid = 1'b0;
      if (q_addr.size() != 0 && q_due[0] <= cyc) begin
        axil.rvalid = 1'b1;
        axil.rdata  = q_addr[0] ^ 32'hA5A5_0000;
        axil.rresp  = (err_en && q_addr[0] == err_addr) ? 2'b10 : 2'b00;
        q_addr.delete(0);
        q_due.delete(0);
      end
      axil.arready = !force_ar_low;
      if (axil.arvalid && axil.arready) begin
        q_addr.push_back(axil.araddr);
        q_due.push_back(cyc + 1 + lat);
        ar_log.push_back(axil.araddr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_one();
    i_Consume = 1'b1;
    step();
    i_Consume = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cyc);
    int n = 0;
    while (!o_Instruction_Valid && n < max_cyc) begin
      step();
      n++;
    end
    chk(tag, 32'(o_Instruction_Valid), 32'd1);
  endtask

  task automatic do_reset();
    i_Reset         = 1'b1;
    i_Enable        = 1'b0;
    i_Consume       = 1'b0;
    i_Redirect      = 1'b0;
    i_Redirect_Addr = '0;
    step();
    step();
    i_Reset = 1'b0;
    ar_log.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Straight-line fetch, zero-latency slave
    lat = 0;
    do_reset();
    chk("rst_valid", 32'(o_Instruction_Valid), 32'd0);
    chk("rst_arvalid", 32'(axil.arvalid), 32'd0);
    chk("rst_rready", 32'(axil.rready), 32'd0);
    chk("rst_pc", o_PC, 32'h0);
    i_Enable  = 1'b1;
    i_Consume = 1'b1;
    step();
    chk("first_arvalid", 32'(axil.arvalid), 32'd1);
    chk("first_araddr", axil.araddr, 32'h0);
    chk("rready_up", 32'(axil.rready), 32'd1);
    step();
    chk("lat_valid_c1", 32'(o_Instruction_Valid), 32'd0);
    step();
    for (int i = 0; i < 6; i++) begin
      chk("line_valid", 32'(o_Instruction_Valid), 32'd1);
      chk("line_pc", o_PC, 32'(4 * i));
      chk("line_instr", o_Instruction, 32'(4 * i) ^ 32'hA5A5_0000);
      step();
    end

    // Backpressure: FIFO fills and issue stops at DEPTH
    do_reset();
    i_Enable = 1'b1;
    repeat (15) step();
    chk("bp_ar_count", 32'(ar_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("bp_ar_addr", ar_log[i], 32'(4 * i));
    chk("bp_arvalid", 32'(axil.arvalid), 32'd0);
    chk("bp_head_pc", o_PC, 32'h0);
    pop_one();
    chk("bp_pop_pc", o_PC, 32'h4);
    repeat (8) step();
    chk("bp_ar_count2", 32'(ar_log.size()), 32'd5);
    chk("bp_ar_0x10", ar_log[4], 32'h10);
    chk("bp_valid_pre", 32'(o_Instruction_Valid), 32'd1);
    i_Redirect      = 1'b1;
    i_Redirect_Addr = 32'h40;
    #1;
    chk("redir_masks_valid", 32'(o_Instruction_Valid), 32'd0);
    step();
    i_Redirect = 1'b0;

    // Redirect with three reads in flight, 3-cycle slave
    lat = 3;
    do_reset();
    i_Enable  = 1'b1;
    i_Consume = 1'b1;
    step();
    step();
    step();
    i_Enable = 1'b0;
    step();
    chk("rd_arvalid_idle", 32'(axil.arvalid), 32'd0);
    i_Redirect      = 1'b1;
    i_Redirect_Addr = 32'h100;
    i_Enable        = 1'b1;
    step();
    i_Redirect = 1'b0;
    wait_valid("rd_first_valid", 20);
    chk("rd_first_pc", o_PC, 32'h100);
    chk("rd_first_instr", o_Instruction, 32'hA5A5_0100);
    step();
    wait_valid("rd_second_valid", 20);
    chk("rd_second_pc", o_PC, 32'h104);
    chk("rd_ar_count", 32'(ar_log.size() >= 4), 32'd1);
    chk("rd_ar_new", ar_log[3], 32'h100);

    // Held arvalid across a redirect while arready is low
    lat          = 0;
    force_ar_low = 1'b1;
    do_reset();
    i_Enable  = 1'b1;
    i_Consume = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_arvalid", 32'(axil.arvalid), 32'd1);
      chk("hold_araddr", axil.araddr, 32'h0);
      i_Redirect      = (i == 1);
      i_Redirect_Addr = 32'h203;
      step();
    end
    i_Redirect   = 1'b0;
    force_ar_low = 1'b0;
    step();
    chk("hold_new_arvalid", 32'(axil.arvalid), 32'd1);
    chk("hold_new_araddr", axil.araddr, 32'h200);
    wait_valid("hold_valid", 20);
    chk("hold_pc", o_PC, 32'h200);
    chk("hold_instr", o_Instruction, 32'hA5A5_0200);
    chk("hold_ar_first", ar_log[0], 32'h0);
    chk("hold_ar_second", ar_log[1], 32'h200);

    // Error response on PC 0x8
    err_en   = 1'b1;
    err_addr = 32'h8;
    do_reset();
    i_Enable = 1'b1;
    repeat (12) step();
    chk("err_pc0", o_PC, 32'h0);
    chk("err_flag0", 32'(o_Fetch_Error), 32'd0);
    pop_one();
    chk("err_pc4", o_PC, 32'h4);
    chk("err_flag4", 32'(o_Fetch_Error), 32'd0);
    pop_one();
    chk("err_pc8", o_PC, 32'h8);
    chk("err_flag8", 32'(o_Fetch_Error), 32'd1);
    chk("err_instr8", o_Instruction, 32'hA5A5_0008);
    pop_one();
    chk("err_pcC", o_PC, 32'hC);
    chk("err_flagC", 32'(o_Fetch_Error), 32'd0);
    err_en = 1'b0;

    // Enable drop mid-stream, then a one-cycle reset
    lat = 3;
    do_reset();
    i_Enable = 1'b1;
    step();
    step();
    i_Enable = 1'b0;
    repeat (10) step();
    chk("en_arvalid", 32'(axil.arvalid), 32'd0);
    chk("en_ar_count", 32'(ar_log.size()), 32'd2);
    chk("en_valid", 32'(o_Instruction_Valid), 32'd1);
    chk("en_pc0", o_PC, 32'h0);
    chk("en_instr0", o_Instruction, 32'hA5A5_0000);
    pop_one();
    chk("en_pc4", o_PC, 32'h4);
    i_Reset = 1'b1;
    step();
    chk("r1_valid", 32'(o_Instruction_Valid), 32'd0);
    chk("r1_pc", o_PC, 32'h0);
    chk("r1_instr", o_Instruction, 32'h0);
    chk("r1_err", 32'(o_Fetch_Error), 32'd0);
    chk("r1_arvalid", 32'(axil.arvalid), 32'd0);
    chk("r1_araddr", axil.araddr, 32'h0);
    chk("r1_rready", 32'(axil.rready), 32'd0);
    i_Reset  = 1'b0;
    i_Enable = 1'b1;
    ar_log.delete();
    step();
    chk("r1_next_arvalid", 32'(axil.arvalid), 32'd1);
    chk("r1_next_araddr", axil.araddr, 32'h0);
    wait_valid("r1_valid_after", 20);
    chk("r1_head_pc", o_PC, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/instruction_prefetch_unit.md
# instruction_prefetch_unit

Fetch front end that feeds pipeline stage 1 of the `cpu` core. It replaces the single-shot instruction read with a credit-limited AXI-Lite read master that keeps up to `DEPTH` fetches in flight. Returned words are buffered in a small FIFO tagged with their PC. Control-flow redirects flush the FIFO and silently discard responses to fetches that were issued before the redirect.

## Interface
Parameters:
- `XLEN`, 32: data and address width.
- `DEPTH`, 4: FIFO entries, which is also the maximum number of outstanding reads. Power of two, minimum 2.
- `RESET_ADDR`, 32'h0000_0000: first fetch address after reset.

Ports:
- `i_Clock`  in  1  single clock for the whole block.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Enable`  in  1  memory calibration complete. While low, no new AR is issued.
- `i_Redirect`  in  1  one-cycle pulse that replaces the fetch stream.
- `i_Redirect_Addr`  in  XLEN  new fetch PC. Bits [1:0] are ignored and forced to 0.
- `i_Consume`  in  1  stage 1 accepts the head entry this cycle.
- `o_Instruction`  out  XLEN  head instruction word.
- `o_PC`  out  XLEN  address of the head instruction.
- `o_Fetch_Error`  out  1  head entry returned with rresp != OKAY.
- `o_Instruction_Valid`  out  1  head entry is present and usable.
- `s_axil_araddr`  out  XLEN  read address.
- `s_axil_arvalid`  out  1  read address valid.
- `s_axil_arready`  in  1  read address ready.
- `s_axil_rdata`  in  XLEN  read data.
- `s_axil_rresp`  in  2  read response.
- `s_axil_rvalid`  in  1  read data valid.
- `s_axil_rready`  out  1  read data ready. Held at constant 1 outside reset.

## Operation
- **State:**
  - `r_Fetch_PC`: next address to request.
  - `r_Inflight`: count of ARs accepted without their R beat.
  - `r_Discard`: count of stale beats still to drop.
  - The FIFO itself.
  - Counter width for all three is `$clog2(DEPTH+1)`.
- **AR issue:**
  - `arvalid` rises when `i_Enable` is high, `arvalid` is currently low, and fifo_count + r_Inflight + pending_ar < DEPTH.
  - `araddr` = `r_Fetch_PC` at the moment of assertion.
  - `arvalid` and `araddr` are held stable until `arready`, per AXI rules, even across a redirect or `i_Enable` falling.
  - On the handshake, `r_Inflight` increments and `r_Fetch_PC` += 4. Wrap from 32'hFFFF_FFFC to 0 is allowed.
- **R accept:** every `rvalid` beat is accepted.
  - If `r_Discard` > 0, the beat is dropped and `r_Discard` decrements.
  - Otherwise the FIFO is pushed with {PC, rdata, rresp != 2'b00}. The PC comes from an internal expected-PC register, which advances by 4 per push.
  - `r_Inflight` decrements in both cases.
  - The credit rule guarantees no push ever occurs while the FIFO is full. A push while full is an assertion failure.
- **Output:**
  - `o_Instruction_Valid` = FIFO not empty && !`i_Redirect`.
  - `i_Consume` while `o_Instruction_Valid` is high pops the head.
  - `i_Consume` while `o_Instruction_Valid` is low is ignored.
- **Redirect:** in the same clock edge:
  - The FIFO is cleared.
  - `r_Fetch_PC` and expected-PC are set to the aligned `i_Redirect_Addr`.
  - `r_Discard` is set to r_Inflight + (arvalid ? 1 : 0) − (beat accepted this cycle ? 1 : 0), so every earlier request is dropped.
  - A pending `arvalid` completes normally and its beat is discarded.
- **Priorities:**
  - Redirect beats consume.
  - A same-cycle push and pop are both performed, leaving the count unchanged.
  - An R beat arriving in the redirect cycle is stale and is dropped.
- **Reset:**
  - All counters clear, the FIFO empties, `r_Fetch_PC` = `RESET_ADDR`, `arvalid` = 0, and all outputs are 0.
  - `i_Reset` is shared with the interconnect, so no stale beat survives reset.

## Timing
- First `arvalid` is asserted in the first cycle after reset deasserts with `i_Enable` high.
- Head-valid latency: AR handshake + slave latency + 1 cycle. The FIFO write is registered and there is no rdata-to-output bypass.
- Sustained throughput is one instruction per cycle when the slave accepts one AR per cycle and returns one R beat per cycle.
- Redirect → first AR at the new address is the next cycle if `arvalid` is idle. Otherwise it follows one cycle after the pending handshake.
- `o_Instruction`, `o_PC` and `o_Fetch_Error` come from FIFO registers only. There is no combinational path from AXI inputs to any output.

## Structure
- The AXI response code `AXI_RESP_OKAY` (2'b00) and `RESET_ADDR` go in the shared `cpu_core_params.vh`.
- Sub-module `fetch_fifo`:
  - Parameterised width and depth.
  - Synchronous clear input.
  - Registered head.
  - Push/pop with a count output.
- The credit, discard and AR logic stays in the parent.

## Test plan
- **Straight-line fetch:** reset, zero-latency slave returning addr^32'hA5A5_0000, `i_Consume` held high. Expect PCs 0, 4, 8, … on consecutive cycles after the initial latency, with matching data.
- **Backpressure:** `i_Consume` held low. Expect exactly `DEPTH` ARs (0x0–0xC) and no fifth AR. One consume then yields one AR at 0x10.
- **Redirect with fetches outstanding:** 3-cycle slave, redirect to 0x100 while 3 reads are in flight. Expect all 3 beats dropped, the first valid head at PC 0x100, and no stale data visible.
- **Held `arvalid`:** slave holds `arready` low for 5 cycles, redirect during the stall. Expect `araddr` unchanged until the handshake, that beat discarded, and the next AR at the redirect address.
- **Error response:** rresp = 2'b10 on PC 0x8. Expect `o_Fetch_Error` = 1 only while that entry is the head.
- **Enable drop and reset:** drop `i_Enable` mid-stream. Expect no new ARs and in-flight beats still buffered. Then assert `i_Reset` for 1 cycle. Expect all outputs 0 and the next AR at `RESET_ADDR`.
